// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle for alu_pipe.
// master = producer of operations and consumer of results (execute stage),
// slave  = the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       codop;
  logic [WIDTH-1:0] operando1;
  logic [WIDTH-1:0] operando2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic             neg;
  logic             zero;
  logic             overflow;
  logic             taken;
  logic             busy;

  modport master (
    output in_valid, codop, operando1, operando2, out_ready,
    input  in_ready, out_valid, resultado, neg, zero, overflow, taken, busy
  );

  modport slave (
    input  in_valid, codop, operando1, operando2, out_ready,
    output in_ready, out_valid, resultado, neg, zero, overflow, taken, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready flow control on both sides.
// One operation is accepted per handshake; result and flags are captured
// together in an output register and held until the consumer takes them.
// Build option ALU_MUL_EN: when defined, opcode 13 runs an iterative
// shift-add multiplier (one multiplier bit per cycle, WIDTH cycles);
// when undefined, opcode 13 returns 0 with single-cycle latency and no
// multiplier logic exists.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       reset_n,
  alu_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             tkn;
  } alu_out_t;

  // Single-cycle opcode evaluation; opcode 13 falls to the zero default and
  // is only overridden by the multiplier path when it is built.
  function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t         r;
    logic [WIDTH-1:0] t;
    r = '0;
    t = '0;
    case (op)
      4'd0, 4'd9: begin
        t     = a + b;
        r.res = t;
        r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        t     = a - b;
        r.res = t;
        r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
      end
      4'd10: begin
        t     = b - a;
        r.res = t;
        r.ovf = (b[WIDTH-1] != a[WIDTH-1]) && (t[WIDTH-1] != b[WIDTH-1]);
      end
      4'd2:       r.res = {{(WIDTH-1){1'b0}}, (b > a)};
      4'd3, 4'd6: r.res = a & b;
      4'd4, 4'd7: r.res = a | b;
      4'd5, 4'd8: r.res = a ^ b;
      4'd11:      r.res = a;
      4'd12: begin
        if (a == {WIDTH{1'b0}}) begin
          r.res = b;
          r.tkn = 1'b1;
        end else begin
          r.res = {WIDTH{1'b0}};
          r.tkn = 1'b0;
        end
      end
      default:    r.res = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  state_t           state;
  logic             out_valid;
  logic [WIDTH-1:0] resultado;
  logic             neg;
  logic             zero;
  logic             overflow;
  logic             taken;
  logic             accept;
  alu_out_t         ev;

  // in_ready must not look at in_valid: it depends only on state and the consumer.
  assign bus.in_ready = (state == IDLE) || ((state == FULL) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign ev           = alu_eval(bus.codop, bus.operando1, bus.operando2);

`ifdef ALU_MUL_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic             is_mul;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  assign is_mul   = (bus.codop == 4'd13);
  assign acc_next = acc + (mplier[0] ? mcand : {WIDTH{1'b0}});
  assign bus.busy = busy;
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.out_valid = out_valid;
  assign bus.resultado = resultado;
  assign bus.neg       = neg;
  assign bus.zero      = zero;
  assign bus.overflow  = overflow;
  assign bus.taken     = taken;

  // Control FSM plus output register; a reset mid-multiply drops the partial product.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      resultado <= {WIDTH{1'b0}};
      neg       <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      taken     <= 1'b0;
`ifdef ALU_MUL_EN
      busy      <= 1'b0;
      mcand     <= {WIDTH{1'b0}};
      mplier    <= {WIDTH{1'b0}};
      acc       <= {WIDTH{1'b0}};
      cnt       <= {CW{1'b0}};
`endif
    end else begin
      case (state)
        IDLE, FULL: begin
`ifdef ALU_MUL_EN
          if (accept && is_mul) begin
            state     <= MUL;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= bus.operando1;
            mplier    <= bus.operando2;
            acc       <= {WIDTH{1'b0}};
            cnt       <= {CW{1'b0}};
          end else
`endif
          if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            resultado <= ev.res;
            neg       <= ev.res[WIDTH-1];
            zero      <= (ev.res == {WIDTH{1'b0}});
            overflow  <= ev.ovf;
            taken     <= ev.tkn;
          end else if ((state == FULL) && bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end else begin
            state     <= state;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + {{(CW-1){1'b0}}, 1'b1};
          if (cnt == LAST) begin
            state     <= FULL;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            resultado <= acc_next;
            neg       <= acc_next[WIDTH-1];
            zero      <= (acc_next == {WIDTH{1'b0}});
            overflow  <= 1'b0;
            taken     <= 1'b0;
          end else begin
            state <= MUL;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven check of alu_pipe at WIDTH=16.
module tb_alu_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        neg;
    logic        zero;
    logic        ovf;
    logic        tkn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] res, input logic neg, input logic zero,
                              input logic ovf, input logic tkn);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res;
    v.neg = neg; v.zero = zero; v.ovf = ovf; v.tkn = tkn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Multiply run: result held with out_ready=0 so the loop sees it, then consumed.
  task automatic mul_test(input logic [15:0] a, input logic [15:0] b, input logic [15:0] prod);
    int n;
    int nbusy;
    int viol;
    int exp_lat;
    logic [15:0] exp_res;
`ifdef ALU_MUL_EN
    exp_lat = 16;
    exp_res = prod;
`else
    exp_lat = 0;
    exp_res = 16'h0000;
`endif
    n = 0; nbusy = 0; viol = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.codop     = 4'd13;
    bus.operando1 = a;
    bus.operando2 = b;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.codop     = 4'd0;
    bus.operando1 = 16'hFFFF;
    bus.operando2 = 16'hFFFF;
    #1;
    while (!bus.out_valid && n < 40) begin
      if (bus.busy) begin
        nbusy++;
        if (bus.in_ready) viol++;
      end
      tick();
      n++;
    end
    check("mul_busy_cycles", 32'(nbusy), 32'(exp_lat));
    check("mul_latency", 32'(n), 32'(exp_lat));
    check("mul_ready_while_busy", 32'(viol), 32'd0);
    check("mul_result", {11'd0, bus.out_valid, bus.resultado, bus.overflow, bus.taken, bus.busy},
          {11'd0, 1'b1, exp_res, 1'b0, 1'b0, 1'b0});
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    logic [15:0] held;
    logic        hold_valid;
    logic [15:0] expq[$];

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.codop     = 4'd0;
    bus.operando1 = 16'h0000;
    bus.operando2 = 16'h0000;
    bus.out_ready = 1'b0;

    vecs.push_back(mk(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'd9,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd0,  16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'd1,  16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 16'h0005, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd10, 16'h0001, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(4'd2,  16'h0003, 16'h0005, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd2,  16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd2,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd2,  16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd6,  16'hFFFF, 16'h8001, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd4,  16'hF000, 16'h000F, 16'hF00F, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd7,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd5,  16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd8,  16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd11, 16'h8001, 16'h1111, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 16'h0000, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(4'd12, 16'h0007, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd12, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(4'd3,  16'h7FFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4'd14, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));

    // Reset state.
    #1;
    check("reset_outputs", {25'd0, bus.out_valid, bus.neg, bus.zero, bus.overflow, bus.taken, bus.busy, bus.in_ready},
          {25'd0, 6'b000000, 1'b1});
    check("reset_result", 32'(bus.resultado), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});

    // Table-driven single ops, streamed one per cycle with out_ready high.
    bus.out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.in_valid  = 1'b1;
      bus.codop     = vecs[i].op;
      bus.operando1 = vecs[i].a;
      bus.operando2 = vecs[i].b;
      tick();
      check($sformatf("vec%0d_op%0d", i, vecs[i].op),
            {9'd0, bus.in_ready, bus.out_valid, bus.busy, bus.resultado, bus.neg, bus.zero, bus.overflow, bus.taken},
            {9'd0, 1'b1, 1'b1, 1'b0, vecs[i].res, vecs[i].neg, vecs[i].zero, vecs[i].ovf, vecs[i].tkn});
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_after_table", {31'd0, bus.out_valid}, 32'd0);

    // Stream of 8 adds with a 3-cycle consumer stall in the middle.
    sent = 0; got = 0; cyc = 0; hold_valid = 1'b0; held = 16'h0000;
    while (got < 8 && cyc < 60) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      if (sent < 8) begin
        bus.in_valid  = 1'b1;
        bus.codop     = 4'd0;
        bus.operando1 = 16'(sent) * 16'd257;
        bus.operando2 = 16'h0100;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (hold_valid) check("stall_hold", 32'(bus.resultado), 32'(held));
        held = bus.resultado;
        hold_valid = 1'b1;
      end else begin
        hold_valid = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        if (expq.size() == 0) check("stream_extra", 32'(bus.resultado), 32'hDEAD_BEEF);
        else check($sformatf("stream_%0d", got), 32'(bus.resultado), 32'(expq.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(bus.operando1 + bus.operando2);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stream_count", 32'(got), 32'd8);
    check("stream_leftover", 32'(expq.size()), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Multiply (or its zero stand-in when the multiplier is not built).
    mul_test(16'h0123, 16'h0010, 16'h1230);
    mul_test(16'h00FF, 16'h0101, 16'hFFFF);

    // Reset asserted part-way through a multiply.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.codop     = 4'd13;
    bus.operando1 = 16'h0123;
    bus.operando2 = 16'h0010;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
`ifdef ALU_MUL_EN
    check("busy_before_abort", {31'd0, bus.busy}, 32'd1);
`else
    check("busy_before_abort", {31'd0, bus.busy}, 32'd0);
`endif
    reset_n = 1'b0;
    #1;
    check("abort_outputs", {25'd0, bus.out_valid, bus.neg, bus.zero, bus.overflow, bus.taken, bus.busy, bus.in_ready},
          {25'd0, 6'b000000, 1'b1});
    check("abort_result", 32'(bus.resultado), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    check("after_abort_idle", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
